// File: rtl/kernel_acc_if.sv
// Handshake bundle between the product source, kernel_acc and the bias stage.
interface kernel_acc_if #(
  parameter int unsigned P_BW  = 16,
  parameter int unsigned AK_BW = 20
) ();
  logic             i_valid;
  logic [P_BW-1:0]  i_prod;
  logic             o_in_ready;
  logic             i_clear;
  logic             o_valid;
  logic [AK_BW-1:0] o_acc_kernel;
  logic             i_ready;
  logic             o_ovf;

  // Upstream source plus downstream sink, as seen from outside the accumulator.
  modport master (
    output i_valid, i_prod, i_clear, i_ready,
    input  o_in_ready, o_valid, o_acc_kernel, o_ovf
  );

  // The accumulator itself.
  modport slave (
    input  i_valid, i_prod, i_clear, i_ready,
    output o_in_ready, o_valid, o_acc_kernel, o_ovf
  );
endinterface

// File: rtl/kernel_acc.sv
// Kernel-window accumulator: sums KERNEL_N unsigned products per window and
// presents each window sum on a registered valid/ready output.
module kernel_acc #(
  parameter int unsigned P_BW     = 16,
  parameter int unsigned KERNEL_N = 9,
  parameter int unsigned AK_BW    = 20,
  parameter int unsigned CNT_BW   = $clog2(KERNEL_N)
) (
  input logic         clk,
  input logic         rst,
  kernel_acc_if.slave bus
);

  localparam int unsigned SUM_BW   = AK_BW + 1;
  localparam logic [CNT_BW-1:0] CNT_LAST = CNT_BW'(KERNEL_N - 1);

  // acc[AK_BW] is a sticky carry: once any partial sum of the window spills
  // past AK_BW bits the window is known to overflow, even if later adds wrap.
  logic [AK_BW:0]    acc;
  logic [CNT_BW-1:0] cnt;
  logic              valid_q;
  logic [AK_BW-1:0]  acc_kernel_q;
  logic              ovf_q;

  logic [P_BW-1:0]   prod_c;
  logic [AK_BW:0]    sum_c;
  logic              last_c;
  logic              in_ready_c;
  logic              accept_c;
  logic              consume_c;

  // Adder, handshake decode and input-ready.
  always_comb begin
    prod_c     = bus.i_prod;
    sum_c      = {1'b0, acc[AK_BW-1:0]} + SUM_BW'(prod_c);
    last_c     = (cnt == CNT_LAST);
    in_ready_c = !last_c || !valid_q || bus.i_ready;
    accept_c   = bus.i_valid && in_ready_c && !bus.i_clear;
    consume_c  = valid_q && bus.i_ready;
  end

  // Accumulator, element counter, output register and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      cnt          <= '0;
      valid_q      <= 1'b0;
      acc_kernel_q <= '0;
      ovf_q        <= 1'b0;
    end else begin
      if (consume_c) begin
        valid_q <= 1'b0;
      end
      if (bus.i_clear) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept_c) begin
        if (last_c) begin
          acc_kernel_q <= sum_c[AK_BW-1:0];
          valid_q      <= 1'b1;
          if (acc[AK_BW] || sum_c[AK_BW]) begin
            ovf_q <= 1'b1;
          end
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= {acc[AK_BW] | sum_c[AK_BW], sum_c[AK_BW-1:0]};
          cnt <= cnt + CNT_BW'(1);
        end
      end
    end
  end

  // Drive the bundle outputs.
  always_comb begin
    bus.o_in_ready   = in_ready_c;
    bus.o_valid      = valid_q;
    bus.o_acc_kernel = acc_kernel_q;
    bus.o_ovf        = ovf_q;
  end

endmodule

// File: tb/tb_kernel_acc.sv
// Directed bench for kernel_acc: vector table on a 20-bit instance, plus a
// hand-written overflow sequence on a 16-bit instance.
module tb_kernel_acc;

  logic clk;
  logic rst_a;
  logic rst_b;

  kernel_acc_if #(.P_BW(16), .AK_BW(20)) bus_a ();
  kernel_acc_if #(.P_BW(16), .AK_BW(16)) bus_b ();

  kernel_acc #(.P_BW(16), .KERNEL_N(9), .AK_BW(20)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  kernel_acc #(.P_BW(16), .KERNEL_N(9), .AK_BW(16)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        valid;
    logic [15:0] prod;
    logic        clr;
    logic        rdy;
    logic        e_in_rdy;
    logic        e_valid;
    logic [19:0] e_acc;
    logic        e_ovf;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   bad;

  function automatic void add(input logic r, input logic v, input logic [15:0] p,
                              input logic c, input logic rd, input logic eir,
                              input logic ev, input logic [19:0] ea, input logic eo);
    vec_t x;
    x.rst = r; x.valid = v; x.prod = p; x.clr = c; x.rdy = rd;
    x.e_in_rdy = eir; x.e_valid = ev; x.e_acc = ea; x.e_ovf = eo;
    vq.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive_b(input logic v, input logic [15:0] p, input logic rd);
    bus_b.i_valid = v;
    bus_b.i_prod  = p;
    bus_b.i_ready = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.i_valid = 1'b0; bus_a.i_prod = '0; bus_a.i_clear = 1'b0; bus_a.i_ready = 1'b0;
    bus_b.i_valid = 1'b0; bus_b.i_prod = '0; bus_b.i_clear = 1'b0; bus_b.i_ready = 1'b0;

    // basic window 1..9
    for (int k = 1; k <= 9; k++) add(0, 1, 16'(k), 0, 1, 1, k == 9, (k == 9) ? 20'd45 : 20'd0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 20'd45, 0);
    // back-to-back 18 x 0xFFFF
    for (int k = 1; k <= 18; k++)
      add(0, 1, 16'hFFFF, 0, 1, 1, (k == 9) || (k == 18), (k < 9) ? 20'd45 : 20'd589815, 0);
    add(0, 0, 0, 0, 1, 1, 0, 20'd589815, 0);
    // backpressure: 45 held, next window of 2s stalls at its final element
    for (int k = 1; k <= 9; k++) add(0, 1, 16'(k), 0, 0, 1, k == 9, (k == 9) ? 20'd45 : 20'd589815, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 16'd2, 0, 0, 1, 1, 20'd45, 0);
    add(0, 1, 16'd2, 0, 0, 0, 1, 20'd45, 0);
    add(0, 1, 16'd2, 0, 0, 0, 1, 20'd45, 0);
    add(0, 1, 16'd2, 0, 1, 1, 1, 20'd18, 0);
    add(0, 0, 0, 0, 1, 1, 0, 20'd18, 0);
    // clear mid-window discards 5,5,5 and the 7
    for (int k = 1; k <= 3; k++) add(0, 1, 16'd5, 0, 1, 1, 0, 20'd18, 0);
    add(0, 1, 16'd7, 1, 1, 1, 0, 20'd18, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 16'(k), 0, 1, 1, k == 9, (k == 9) ? 20'd45 : 20'd18, 0);
    add(0, 0, 0, 0, 1, 1, 0, 20'd45, 0);
    // reset with a held output and 4 accepted products
    for (int k = 1; k <= 9; k++) add(0, 1, 16'd3, 0, 0, 1, k == 9, (k == 9) ? 20'd27 : 20'd45, 0);
    for (int k = 1; k <= 4; k++) add(0, 1, 16'd1, 0, 0, 1, 1, 20'd27, 0);
    add(1, 0, 0, 0, 0, 1, 0, 20'd0, 0);
    for (int k = 1; k <= 9; k++) add(0, 1, 16'(k), 0, 1, 1, k == 9, (k == 9) ? 20'd45 : 20'd0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;
    chk("reset_valid", 32'(bus_a.o_valid), 32'd0);
    chk("reset_acc", 32'(bus_a.o_acc_kernel), 32'd0);
    chk("reset_ovf", 32'(bus_a.o_ovf), 32'd0);
    chk("reset_in_ready", 32'(bus_a.o_in_ready), 32'd1);

    // table-driven run on the 20-bit instance
    for (int i = 0; i < vq.size(); i++) begin
      rst_a         = vq[i].rst;
      bus_a.i_valid = vq[i].valid;
      bus_a.i_prod  = vq[i].prod;
      bus_a.i_clear = vq[i].clr;
      bus_a.i_ready = vq[i].rdy;
      #1;
      chk($sformatf("row%0d_in_ready", i), 32'(bus_a.o_in_ready), 32'(vq[i].e_in_rdy));
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_valid", i), 32'(bus_a.o_valid), 32'(vq[i].e_valid));
      chk($sformatf("row%0d_acc", i), 32'(bus_a.o_acc_kernel), 32'(vq[i].e_acc));
      chk($sformatf("row%0d_ovf", i), 32'(bus_a.o_ovf), 32'(vq[i].e_ovf));
    end
    rst_a = 1'b0;
    bus_a.i_valid = 1'b0;
    bus_a.i_clear = 1'b0;

    // overflow on the 16-bit instance: 9 x 0xFFFF wraps to 0xFFF7
    rst_b = 1'b0;
    chk("b_reset_ovf", 32'(bus_b.o_ovf), 32'd0);
    for (int k = 1; k <= 8; k++) drive_b(1'b1, 16'hFFFF, 1'b1);
    chk("b_pre_final_valid", 32'(bus_b.o_valid), 32'd0);
    chk("b_pre_final_ovf", 32'(bus_b.o_ovf), 32'd0);
    drive_b(1'b1, 16'hFFFF, 1'b1);
    chk("b_ovf_valid", 32'(bus_b.o_valid), 32'd1);
    chk("b_ovf_acc", 32'(bus_b.o_acc_kernel), 32'h0000FFF7);
    chk("b_ovf_flag", 32'(bus_b.o_ovf), 32'd1);
    // following normal window keeps the sticky flag
    for (int k = 1; k <= 8; k++) drive_b(1'b1, 16'(k), 1'b1);
    chk("b_mid_valid", 32'(bus_b.o_valid), 32'd0);
    bus_b.i_valid = 1'b1;
    bus_b.i_prod  = 16'd9;
    @(posedge clk);
    #1;
    bus_b.i_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (!bus_b.o_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("b_wait_valid_cycles", 32'(n), 32'd0);
    end
    chk("b_norm_acc", 32'(bus_b.o_acc_kernel), 32'd45);
    chk("b_norm_ovf", 32'(bus_b.o_ovf), 32'd1);
    drive_b(1'b0, 16'd0, 1'b1);
    chk("b_after_consume_valid", 32'(bus_b.o_valid), 32'd0);
    chk("b_after_consume_ovf", 32'(bus_b.o_ovf), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
